// File: rtl/br_tag_manager_if.sv
// Branch tag manager bus: dispatch allocation, branch-unit resolution and the
// b1/b2 branch-update outputs that br_mask holders consume.
//   master : dispatch / branch-unit side (drives flush, alloc_valid, resolve_*)
//   slave  : br_tag_manager (drives alloc_*, b1_*, b2_*, br_count, outstanding)
// Optional macro BR_TAG_ERR_CHECK_EN adds err / err_count to the slave side.
interface br_tag_manager_if #(
  parameter int unsigned MAX_BR_COUNT = 16,
  parameter int unsigned TAG_W        = $clog2(MAX_BR_COUNT)
);
  logic                    flush;
  logic                    alloc_valid;
  logic                    alloc_ready;
  logic [TAG_W-1:0]        alloc_tag;
  logic [MAX_BR_COUNT-1:0] alloc_br_mask;
  logic                    resolve_valid;
  logic [TAG_W-1:0]        resolve_tag;
  logic                    resolve_mispredict;
  logic [MAX_BR_COUNT-1:0] b1_resolve_mask;
  logic [MAX_BR_COUNT-1:0] b1_mispredict_mask;
  logic                    b2_valid;
  logic [TAG_W-1:0]        b2_tag;
  logic [TAG_W:0]          br_count;
  logic [MAX_BR_COUNT-1:0] outstanding;
`ifdef BR_TAG_ERR_CHECK_EN
  logic                    err;
  logic [7:0]              err_count;

  modport master (
    output flush, alloc_valid, resolve_valid, resolve_tag, resolve_mispredict,
    input  alloc_ready, alloc_tag, alloc_br_mask, b1_resolve_mask,
           b1_mispredict_mask, b2_valid, b2_tag, br_count, outstanding,
           err, err_count
  );
  modport slave (
    input  flush, alloc_valid, resolve_valid, resolve_tag, resolve_mispredict,
    output alloc_ready, alloc_tag, alloc_br_mask, b1_resolve_mask,
           b1_mispredict_mask, b2_valid, b2_tag, br_count, outstanding,
           err, err_count
  );
`else
  modport master (
    output flush, alloc_valid, resolve_valid, resolve_tag, resolve_mispredict,
    input  alloc_ready, alloc_tag, alloc_br_mask, b1_resolve_mask,
           b1_mispredict_mask, b2_valid, b2_tag, br_count, outstanding
  );
  modport slave (
    input  flush, alloc_valid, resolve_valid, resolve_tag, resolve_mispredict,
    output alloc_ready, alloc_tag, alloc_br_mask, b1_resolve_mask,
           b1_mispredict_mask, b2_valid, b2_tag, br_count, outstanding
  );
`endif
endinterface

// File: rtl/br_tag_manager.sv
// Branch tag manager: allocates branch tags at dispatch, hands out each new
// uop's br_mask, tracks outstanding branches and their age dependencies, and
// turns branch-unit resolutions into b1 (resolve/mispredict masks) and b2
// (mispredict redirect tag) updates.
// Ports: clock, reset (async, active-high), io (br_tag_manager_if.slave).
// Optional macro BR_TAG_ERR_CHECK_EN: sticky io.err and saturating
// io.err_count for resolves of tags that are not outstanding.
// Timing: resolve -> b1 one cycle later; outstanding/dep are updated from the
// registered b1 masks, so a freed tag is allocatable the cycle after b1, and
// b2 pulses in that same cycle.
module br_tag_manager #(
  parameter int unsigned MAX_BR_COUNT = 16
) (
  input  logic           clock,
  input  logic           reset,
  br_tag_manager_if.slave io
);
  localparam int unsigned N     = MAX_BR_COUNT;
  localparam int unsigned TAG_W = $clog2(MAX_BR_COUNT);
  localparam int unsigned CNT_W = TAG_W + 1;

  logic [N-1:0]     outstanding_q, outstanding_d;
  logic [N-1:0]     dep_q [N];
  logic [N-1:0]     dep_d [N];
  logic [N-1:0]     b1_res_q, b1_res_d;
  logic [N-1:0]     b1_mis_q, b1_mis_d;
  logic [TAG_W-1:0] b1_tag_q, b1_tag_d;
  logic             b2_valid_q, b2_valid_d;
  logic [TAG_W-1:0] b2_tag_q, b2_tag_d;
  logic [CNT_W-1:0] br_count_q, br_count_d;

  logic             mispredict_pending;
  logic             alloc_ready;
  logic             grant;
  logic             resolve_legal;
  logic [TAG_W-1:0] free_tag;
  logic [N-1:0]     alloc_br_mask;
  logic [N-1:0]     resolve_oh;
  logic [N-1:0]     grant_oh;
  logic [N-1:0]     kill;
  logic [N-1:0]     release_mask;

  assign mispredict_pending = |b1_mis_q;
  // Stall while a mispredict is on the input or still in b1 so no new uop
  // picks up a mask containing tags about to be squashed.
  assign alloc_ready = !(&outstanding_q) && !io.flush
                    && !(io.resolve_valid && io.resolve_mispredict)
                    && !mispredict_pending;
  assign grant         = io.alloc_valid && alloc_ready;
  assign alloc_br_mask = outstanding_q & ~b1_res_q;

  assign resolve_legal = io.resolve_valid
                      && ({1'b0, io.resolve_tag} < CNT_W'(N))
                      && outstanding_q[io.resolve_tag];
  assign resolve_oh = resolve_legal ? (N'(1) << io.resolve_tag) : '0;
  assign grant_oh   = grant ? (N'(1) << free_tag) : '0;

  // Lowest-index free tag.
  always_comb begin
    free_tag = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (!outstanding_q[i]) free_tag = TAG_W'(i);
    end
  end

  // Mispredicted tag plus every branch allocated after it.
  always_comb begin
    kill = b1_mis_q;
    for (int t = 0; t < int'(N); t++) begin
      if (|(dep_q[t] & b1_mis_q)) kill[t] = 1'b1;
    end
  end

  assign release_mask = b1_res_q | kill;

  // Next-state: apply b1 frees, then the new grant; flush wipes everything.
  always_comb begin
    outstanding_d = (outstanding_q & ~release_mask) | grant_oh;
    for (int t = 0; t < int'(N); t++) begin
      dep_d[t] = release_mask[t] ? '0 : (dep_q[t] & ~b1_res_q);
      if (grant_oh[t]) dep_d[t] = alloc_br_mask;
    end
    b1_res_d   = resolve_oh;
    b1_mis_d   = io.resolve_mispredict ? resolve_oh : '0;
    b1_tag_d   = io.resolve_tag;
    b2_valid_d = mispredict_pending;
    b2_tag_d   = mispredict_pending ? b1_tag_q : b2_tag_q;
    if (io.flush) begin
      outstanding_d = '0;
      for (int t = 0; t < int'(N); t++) dep_d[t] = '0;
      b1_res_d   = '0;
      b1_mis_d   = '0;
      b2_valid_d = 1'b0;
    end
  end

  // Live-tag population count, registered alongside outstanding.
  always_comb begin
    br_count_d = '0;
    for (int t = 0; t < int'(N); t++) br_count_d = br_count_d + CNT_W'(outstanding_d[t]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outstanding_q <= '0;
      for (int t = 0; t < int'(N); t++) dep_q[t] <= '0;
      b1_res_q      <= '0;
      b1_mis_q      <= '0;
      b1_tag_q      <= '0;
      b2_valid_q    <= 1'b0;
      b2_tag_q      <= '0;
      br_count_q    <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      dep_q         <= dep_d;
      b1_res_q      <= b1_res_d;
      b1_mis_q      <= b1_mis_d;
      b1_tag_q      <= b1_tag_d;
      b2_valid_q    <= b2_valid_d;
      b2_tag_q      <= b2_tag_d;
      br_count_q    <= br_count_d;
    end
  end

  assign io.alloc_ready        = alloc_ready;
  assign io.alloc_tag          = free_tag;
  assign io.alloc_br_mask      = alloc_br_mask;
  assign io.b1_resolve_mask    = b1_res_q;
  assign io.b1_mispredict_mask = b1_mis_q;
  assign io.b2_valid           = b2_valid_q;
  assign io.b2_tag             = b2_tag_q;
  assign io.br_count           = br_count_q;
  assign io.outstanding        = outstanding_q;

`ifdef BR_TAG_ERR_CHECK_EN
  logic       illegal_resolve;
  logic       err_q;
  logic [7:0] err_count_q;

  assign illegal_resolve = io.resolve_valid && !resolve_legal;

  // Sticky error flag and saturating count; only reset clears them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else if (illegal_resolve) begin
      err_q <= 1'b1;
      if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
    end
  end

  assign io.err       = err_q;
  assign io.err_count = err_count_q;
`endif
endmodule

// File: tb/tb_br_tag_manager.sv
// Self-checking bench for br_tag_manager: directed allocation/resolve/flush
// sequences, b1/b2 outputs checked through an expected-result scoreboard.
`timescale 1ns/1ps
module tb_br_tag_manager;
  localparam int unsigned N  = 16;
  localparam int unsigned TW = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  br_tag_manager_if #(.MAX_BR_COUNT(N)) io ();
  br_tag_manager #(.MAX_BR_COUNT(N)) dut (.clock(clock), .reset(reset), .io(io.slave));

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { int due; logic [N-1:0] res; logic [N-1:0] mis; } b1_exp_t;
  typedef struct { int due; logic valid; logic [TW-1:0] tag; } b2_exp_t;
  b1_exp_t b1_sb[$];
  b2_exp_t b2_sb[$];

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Pop and compare expected b1/b2 results when they fall due.
  always @(negedge clock) begin
    b1_exp_t e1;
    b2_exp_t e2;
    if (b1_sb.size() > 0 && b1_sb[0].due <= cyc) begin
      e1 = b1_sb.pop_front();
      check_eq("b1_due", 32'(cyc), 32'(e1.due));
      check_eq("b1_resolve_mask", 32'(io.b1_resolve_mask), 32'(e1.res));
      check_eq("b1_mispredict_mask", 32'(io.b1_mispredict_mask), 32'(e1.mis));
    end
    if (b2_sb.size() > 0 && b2_sb[0].due <= cyc) begin
      e2 = b2_sb.pop_front();
      check_eq("b2_due", 32'(cyc), 32'(e2.due));
      check_eq("b2_valid", 32'(io.b2_valid), 32'(e2.valid));
      if (e2.valid) check_eq("b2_tag", 32'(io.b2_tag), 32'(e2.tag));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input int tag, input logic mis, input logic legal);
    logic [N-1:0] oh;
    b1_exp_t e1;
    b2_exp_t e2;
    oh = N'(1) << tag;
    e1.due = cyc + 1;
    e1.res = legal ? oh : '0;
    e1.mis = (legal && mis) ? oh : '0;
    e2.due   = cyc + 2;
    e2.valid = legal && mis;
    e2.tag   = TW'(tag);
    b1_sb.push_back(e1);
    b2_sb.push_back(e2);
  endtask

  task automatic alloc(input int exp_tag, input logic [N-1:0] exp_mask);
    io.alloc_valid = 1'b1;
    #1;
    check_eq("alloc_ready", 32'(io.alloc_ready), 32'd1);
    check_eq("alloc_tag", 32'(io.alloc_tag), 32'(exp_tag));
    check_eq("alloc_br_mask", 32'(io.alloc_br_mask), 32'(exp_mask));
    tick();
    io.alloc_valid = 1'b0;
  endtask

  task automatic resolve(input int tag, input logic mis, input logic legal);
    io.resolve_valid      = 1'b1;
    io.resolve_tag        = TW'(tag);
    io.resolve_mispredict = mis;
    push_exp(tag, mis, legal);
    tick();
    io.resolve_valid      = 1'b0;
    io.resolve_mispredict = 1'b0;
  endtask

  task automatic do_flush();
    io.flush = 1'b1;
    #1;
    check_eq("flush_ready", 32'(io.alloc_ready), 32'd0);
    tick();
    io.flush = 1'b0;
    check_eq("flush_outstanding", 32'(io.outstanding), 32'd0);
    check_eq("flush_br_count", 32'(io.br_count), 32'd0);
  endtask

  initial begin
    logic [N-1:0] m;
    reset                 = 1'b1;
    io.flush              = 1'b0;
    io.alloc_valid        = 1'b0;
    io.resolve_valid      = 1'b0;
    io.resolve_tag        = '0;
    io.resolve_mispredict = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_outstanding", 32'(io.outstanding), 32'd0);
    check_eq("rst_br_count", 32'(io.br_count), 32'd0);
    check_eq("rst_b1_res", 32'(io.b1_resolve_mask), 32'd0);
    check_eq("rst_b1_mis", 32'(io.b1_mispredict_mask), 32'd0);
    check_eq("rst_b2_valid", 32'(io.b2_valid), 32'd0);
    check_eq("rst_b2_tag", 32'(io.b2_tag), 32'd0);
`ifdef BR_TAG_ERR_CHECK_EN
    check_eq("rst_err", 32'(io.err), 32'd0);
    check_eq("rst_err_count", 32'(io.err_count), 32'd0);
`endif
    reset = 1'b0;

    // Three back-to-back allocations.
    alloc(0, 16'h0000);
    alloc(1, 16'h0001);
    alloc(2, 16'h0003);
    check_eq("t1_br_count", 32'(io.br_count), 32'd3);
    check_eq("t1_outstanding", 32'(io.outstanding), 32'h0007);

    // Correct resolve of tag 1; tag 1 reusable once outstanding updates.
    resolve(1, 1'b0, 1'b1);
    check_eq("t2_ready_b1", 32'(io.alloc_ready), 32'd1);
    tick();
    check_eq("t2_outstanding", 32'(io.outstanding), 32'h0005);
    alloc(1, 16'h0005);
    // Alloc during the b1 cycle of a correct resolve: mask omits the resolving tag.
    resolve(2, 1'b0, 1'b1);
    alloc(3, 16'h0003);
    check_eq("t2_outstanding_b", 32'(io.outstanding), 32'h000B);
    check_eq("t2_br_count_b", 32'(io.br_count), 32'd3);

    // Mispredict of tag 1 squashes younger tags 2 and 3.
    do_flush();
    alloc(0, 16'h0000);
    alloc(1, 16'h0001);
    alloc(2, 16'h0003);
    alloc(3, 16'h0007);
    io.alloc_valid        = 1'b1;
    io.resolve_valid      = 1'b1;
    io.resolve_tag        = TW'(1);
    io.resolve_mispredict = 1'b1;
    push_exp(1, 1'b1, 1'b1);
    #1;
    check_eq("t3_ready_in", 32'(io.alloc_ready), 32'd0);
    tick();
    io.resolve_valid      = 1'b0;
    io.resolve_mispredict = 1'b0;
    check_eq("t3_ready_b1", 32'(io.alloc_ready), 32'd0);
    io.alloc_valid = 1'b0;
    tick();
    check_eq("t3_outstanding", 32'(io.outstanding), 32'h0001);
    check_eq("t3_br_count", 32'(io.br_count), 32'd1);
    check_eq("t3_ready_after", 32'(io.alloc_ready), 32'd1);
    check_eq("t3_alloc_tag", 32'(io.alloc_tag), 32'd1);
    tick();

    // Fill all tags, then free tag 5.
    do_flush();
    for (int i = 0; i < int'(N); i++) begin
      m = (N'(1) << i) - N'(1);
      alloc(i, m);
    end
    check_eq("t4_ready_full", 32'(io.alloc_ready), 32'd0);
    check_eq("t4_outstanding", 32'(io.outstanding), 32'hFFFF);
    check_eq("t4_br_count", 32'(io.br_count), 32'd16);
    resolve(5, 1'b0, 1'b1);
    check_eq("t4_ready_b1", 32'(io.alloc_ready), 32'd0);
    tick();
    check_eq("t4_br_count_freed", 32'(io.br_count), 32'd15);
    alloc(5, 16'hFFDF);
    check_eq("t4_ready_refull", 32'(io.alloc_ready), 32'd0);

    // Flush concurrent with a mispredict: no b1/b2 pulse.
    do_flush();
    alloc(0, 16'h0000);
    alloc(1, 16'h0001);
    alloc(2, 16'h0003);
    io.flush = 1'b1;
    resolve(0, 1'b1, 1'b0);
    io.flush = 1'b0;
    check_eq("t5_outstanding", 32'(io.outstanding), 32'd0);
    check_eq("t5_br_count", 32'(io.br_count), 32'd0);
    tick();
    tick();

    // Illegal resolves (free tag) are ignored.
    resolve(7, 1'b0, 1'b0);
`ifdef BR_TAG_ERR_CHECK_EN
    check_eq("t6_err", 32'(io.err), 32'd1);
    check_eq("t6_err_count", 32'(io.err_count), 32'd1);
`endif
    resolve(9, 1'b1, 1'b0);
    check_eq("t6_outstanding", 32'(io.outstanding), 32'd0);
`ifdef BR_TAG_ERR_CHECK_EN
    check_eq("t6_err_count_2", 32'(io.err_count), 32'd2);
`endif
    tick();

    // Asynchronous reset mid-run clears state without a clock edge.
    alloc(0, 16'h0000);
    alloc(1, 16'h0001);
    #2;
    reset = 1'b1;
    #1;
    check_eq("t7_outstanding", 32'(io.outstanding), 32'd0);
    check_eq("t7_br_count", 32'(io.br_count), 32'd0);
`ifdef BR_TAG_ERR_CHECK_EN
    check_eq("t7_err", 32'(io.err), 32'd0);
    check_eq("t7_err_count", 32'(io.err_count), 32'd0);
`endif
    tick();
    reset = 1'b0;
    alloc(0, 16'h0000);
    tick();
    tick();
    check_eq("sb_b1_drained", 32'(b1_sb.size()), 32'd0);
    check_eq("sb_b2_drained", 32'(b2_sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
